// File: rtl/btb_update_writer_pkg.sv
// -----------------------------------------------------------------------------
// btb_update_writer_pkg
//   Shared definitions for the BTB update writer: word/field widths, the BTB
//   invalid-target marker and the packed BTB write-entry layout that travels
//   through the write queue.
// -----------------------------------------------------------------------------
package btb_update_writer_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int BTB_INDEX_W = 8;
  localparam int BTB_TAG_W   = 8;
  localparam int BTB_ENTRY_W = BTB_TAG_W + WORD_SIZE;  // data field: {tag, target}

  // A target of all-ones marks a BTB slot as holding no valid prediction.
  localparam logic [WORD_SIZE-1:0] BTB_INVALID = 16'hFFFF;

  typedef struct packed {
    logic [BTB_INDEX_W-1:0] index;
    logic [BTB_TAG_W-1:0]   tag;
    logic [WORD_SIZE-1:0]   target;
  } btb_wr_entry_t;

  localparam int BTB_WR_ENTRY_BITS = $bits(btb_wr_entry_t);

  // Split a branch PC into BTB index (low byte) and tag (high byte).
  function automatic btb_wr_entry_t make_entry(input logic [WORD_SIZE-1:0] pc,
                                               input logic [WORD_SIZE-1:0] target);
    btb_wr_entry_t e;
    e.index  = pc[BTB_INDEX_W-1:0];
    e.tag    = pc[WORD_SIZE-1:BTB_INDEX_W];
    e.target = target;
    return e;
  endfunction

endpackage

// File: rtl/btb_update_writer_fifo.sv
// -----------------------------------------------------------------------------
// btb_wr_fifo
//   Synchronous FIFO holding pending BTB writes. A push into a full FIFO is
//   accepted only when a pop happens in the same cycle. The newest stored
//   entry is exposed so the writer can suppress back-to-back duplicates.
//
// Parameters
//   DEPTH  number of entries, power of two, >= 2
//   WIDTH  entry width in bits
//
// Ports
//   clk, reset     clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data  write request and entry
//   push_accepted  the push is taken this cycle
//   pop            consume the head entry (ignored when empty)
//   head           oldest entry (meaningful while !empty)
//   newest         most recently written entry (meaningful while !empty)
//   full, empty    occupancy flags
// -----------------------------------------------------------------------------
module btb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_accepted,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] newest,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] newest_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty         = (count == '0);
  assign full          = (count == (PTR_W+1)'(DEPTH));
  assign do_pop        = pop && !empty;
  assign do_push       = push && (!full || do_pop);
  assign push_accepted = do_push;

  // DEPTH is a power of two, so pointer arithmetic wraps on its own.
  assign newest_ptr = wr_ptr - PTR_W'(1);
  assign head       = mem[rd_ptr];
  assign newest     = mem[newest_ptr];

  // NOTE: storage is not reset; emptiness is tracked by the pointers and
  // count alone, and stale words are never observed while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btb_update_writer.sv
// -----------------------------------------------------------------------------
// btb_update_writer
//   Write side of the branch predictor. For every resolved conditional branch
//   it registers a mispredict flush/redirect, pulses the 2-bit counter update,
//   and queues a BTB write that drains one per cycle over a valid/ready port.
//
// Configuration macro
//   BTB_INVALIDATE_EN  when defined, a not-taken branch that fetch followed
//                      as taken queues an invalidation entry (target 16'hFFFF).
//
// Parameters
//   QDEPTH  BTB write queue depth (power of two, >= 2)
//   CNT_W   width of the saturating statistics counters
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   resolve_*                   resolved instruction from branch-resolve stage
//   predicted_pc                next PC fetch used after the branch
//   mispredict, redirect_pc     registered flush pulse and correct next PC
//   ctr_update_valid/_taken     registered 2-bit counter update pulse
//   btb_wr_valid/_ready/_index/_data  BTB write port (queue head)
//   branch_count, mispredict_count, drop_count  saturating statistics
// -----------------------------------------------------------------------------
module btb_update_writer
  import btb_update_writer_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   resolve_valid,
  input  logic                   resolve_is_branch,
  input  logic                   resolve_taken,
  input  logic [WORD_SIZE-1:0]   resolve_pc,
  input  logic [WORD_SIZE-1:0]   resolve_target,
  input  logic [WORD_SIZE-1:0]   predicted_pc,
  output logic                   mispredict,
  output logic [WORD_SIZE-1:0]   redirect_pc,
  output logic                   ctr_update_valid,
  output logic                   ctr_update_taken,
  output logic                   btb_wr_valid,
  input  logic                   btb_wr_ready,
  output logic [BTB_INDEX_W-1:0] btb_wr_index,
  output logic [BTB_ENTRY_W-1:0] btb_wr_data,
  output logic [CNT_W-1:0]       branch_count,
  output logic [CNT_W-1:0]       mispredict_count,
  output logic [CNT_W-1:0]       drop_count
);

  logic                 branch_event;
  logic [WORD_SIZE-1:0] correct_pc;
  logic                 is_mispredict;
  logic                 wants_write;
  logic                 is_dup;
  logic                 push_req;
  logic                 push_accepted;
  logic                 drop;
  logic                 q_full;
  logic                 q_empty;
  logic                 q_pop;
  btb_wr_entry_t        cand;
  btb_wr_entry_t        q_head;
  btb_wr_entry_t        q_newest;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign branch_event  = resolve_valid && resolve_is_branch;
  // 16-bit add wraps, so a fall-through from 16'hFFFF lands on 16'h0000.
  assign correct_pc    = resolve_taken ? resolve_target : resolve_pc + WORD_SIZE'(1);
  assign is_mispredict = (predicted_pc != correct_pc);

  // NOTE: every signal driven here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    wants_write = 1'b0;
    cand        = make_entry(resolve_pc, resolve_target);
    if (branch_event) begin
      if (resolve_taken) begin
        // The invalid marker is never installed as a real target.
        wants_write = (resolve_target != BTB_INVALID);
      end else begin
`ifdef BTB_INVALIDATE_EN
        // Not taken and fetch did not fall through: the BTB steered fetch
        // wrongly, so knock the entry out.
        wants_write = is_mispredict;
        cand        = make_entry(resolve_pc, BTB_INVALID);
`else
        wants_write = 1'b0;
`endif
      end
    end
  end

  // Re-queuing the exact entry just queued would only repeat the same write.
  assign is_dup   = !q_empty && (q_newest == cand);
  assign push_req = wants_write && !is_dup;
  assign drop     = push_req && !push_accepted;
  assign q_pop    = btb_wr_valid && btb_wr_ready;

  btb_wr_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (BTB_WR_ENTRY_BITS)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (push_req),
    .push_data     (cand),
    .push_accepted (push_accepted),
    .pop           (q_pop),
    .head          (q_head),
    .newest        (q_newest),
    .full          (q_full),
    .empty         (q_empty)
  );

  // Head fields are forced to zero while empty so the port never shows stale
  // storage (and reads all-zero straight out of reset).
  assign btb_wr_valid = !q_empty;
  assign btb_wr_index = q_empty ? '0 : q_head.index;
  assign btb_wr_data  = q_empty ? '0 : {q_head.tag, q_head.target};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      ctr_update_valid <= 1'b0;
      ctr_update_taken <= 1'b0;
    end else begin
      mispredict       <= branch_event && is_mispredict;
      ctr_update_valid <= branch_event;
      ctr_update_taken <= branch_event && resolve_taken;
      // redirect_pc holds between branches; consumers qualify it with mispredict.
      if (branch_event) redirect_pc <= correct_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
      drop_count       <= '0;
    end else begin
      if (branch_event)                  branch_count     <= sat_inc(branch_count);
      if (branch_event && is_mispredict) mispredict_count <= sat_inc(mispredict_count);
      if (drop)                          drop_count       <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_btb_update_writer.sv
// -----------------------------------------------------------------------------
// tb_btb_update_writer
//   Directed scenarios plus randomized traffic against a queue-based reference
//   model of the BTB update writer. Narrow statistics counters are used so
//   saturation is reached during the random phase.
// -----------------------------------------------------------------------------
module tb_btb_update_writer;

  localparam int QDEPTH  = 4;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              resolve_valid;
  logic              resolve_is_branch;
  logic              resolve_taken;
  logic [15:0]       resolve_pc;
  logic [15:0]       resolve_target;
  logic [15:0]       predicted_pc;
  logic              mispredict;
  logic [15:0]       redirect_pc;
  logic              ctr_update_valid;
  logic              ctr_update_taken;
  logic              btb_wr_valid;
  logic              btb_wr_ready;
  logic [7:0]        btb_wr_index;
  logic [23:0]       btb_wr_data;
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  mispredict_count;
  logic [CNT_W-1:0]  drop_count;

  btb_update_writer #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .resolve_valid     (resolve_valid),
    .resolve_is_branch (resolve_is_branch),
    .resolve_taken     (resolve_taken),
    .resolve_pc        (resolve_pc),
    .resolve_target    (resolve_target),
    .predicted_pc      (predicted_pc),
    .mispredict        (mispredict),
    .redirect_pc       (redirect_pc),
    .ctr_update_valid  (ctr_update_valid),
    .ctr_update_taken  (ctr_update_taken),
    .btb_wr_valid      (btb_wr_valid),
    .btb_wr_ready      (btb_wr_ready),
    .btb_wr_index      (btb_wr_index),
    .btb_wr_data       (btb_wr_data),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of {index, tag, target} words plus expected
  // registered outputs and statistics.
  logic [31:0] q[$];
  int          m_branch;
  int          m_misp;
  int          m_drop;
  logic        exp_misp;
  logic [15:0] exp_redirect;
  logic        exp_ctr_v;
  logic        exp_ctr_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  task automatic check_outputs();
    logic [31:0] h;
    check("mispredict", 32'(mispredict), 32'(exp_misp));
    check("redirect_pc", 32'(redirect_pc), 32'(exp_redirect));
    check("ctr_update_valid", 32'(ctr_update_valid), 32'(exp_ctr_v));
    check("ctr_update_taken", 32'(ctr_update_taken), 32'(exp_ctr_t));
    check("btb_wr_valid", 32'(btb_wr_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      h = q[0];
      check("btb_wr_index", 32'(btb_wr_index), 32'(h[31:24]));
      check("btb_wr_data", 32'(btb_wr_data), 32'(h[23:0]));
    end
    check("branch_count", 32'(branch_count), 32'(m_branch));
    check("mispredict_count", 32'(mispredict_count), 32'(m_misp));
    check("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input bit v, input bit br, input bit tk,
                      input logic [15:0] pc, input logic [15:0] tgt,
                      input logic [15:0] pred, input bit rdy);
    int          correct;
    bit          pop;
    bit          want;
    bit          push;
    logic [31:0] entry;
    resolve_valid     = v;
    resolve_is_branch = br;
    resolve_taken     = tk;
    resolve_pc        = pc;
    resolve_target    = tgt;
    predicted_pc      = pred;
    btb_wr_ready      = rdy;

    pop   = rdy && (q.size() > 0);
    want  = 1'b0;
    push  = 1'b0;
    entry = '0;
    if (v && br) begin
      correct      = tk ? int'(tgt) : (int'(pc) + 1) % 65536;
      exp_misp     = (int'(pred) != correct);
      exp_redirect = 16'(correct);
      exp_ctr_v    = 1'b1;
      exp_ctr_t    = tk;
      m_branch     = sat(m_branch);
      if (exp_misp) m_misp = sat(m_misp);
      if (tk && tgt != 16'hFFFF) begin
        want  = 1'b1;
        entry = {pc[7:0], pc[15:8], tgt};
      end
`ifdef BTB_INVALIDATE_EN
      else if (!tk && int'(pred) != (int'(pc) + 1) % 65536) begin
        want  = 1'b1;
        entry = {pc[7:0], pc[15:8], 16'hFFFF};
      end
`endif
      if (want && !(q.size() > 0 && q[$] == entry)) begin
        if (q.size() < QDEPTH || pop) push = 1'b1;
        else                          m_drop = sat(m_drop);
      end
    end else begin
      exp_misp  = 1'b0;
      exp_ctr_v = 1'b0;
      exp_ctr_t = 1'b0;
    end
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(entry);

    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, rdy);
  endtask

  task automatic apply_reset();
    resolve_valid     = 1'b0;
    resolve_is_branch = 1'b0;
    resolve_taken     = 1'b0;
    resolve_pc        = '0;
    resolve_target    = '0;
    predicted_pc      = '0;
    btb_wr_ready      = 1'b0;
    reset             = 1'b1;
    q.delete();
    m_branch     = 0;
    m_misp       = 0;
    m_drop       = 0;
    exp_misp     = 1'b0;
    exp_redirect = '0;
    exp_ctr_v    = 1'b0;
    exp_ctr_t    = 1'b0;
    #1;
    // Asynchronous: outputs must already be clear before any clock edge.
    check("rst_btb_wr_valid", 32'(btb_wr_valid), 32'd0);
    check("rst_btb_wr_index", 32'(btb_wr_index), 32'd0);
    check("rst_btb_wr_data", 32'(btb_wr_data), 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    check("rst_ctr_update_valid", 32'(ctr_update_valid), 32'd0);
    check("rst_branch_count", 32'(branch_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] pc_pool  [4] = '{16'h1234, 16'h12FF, 16'hFFFF, 16'h0040};
  logic [15:0] tgt_pool [4] = '{16'h1300, 16'hFFFF, 16'h0005, 16'h0040};

  initial begin
    reset = 1'b0;
    #2;
    apply_reset();

    // Taken branch, fetch fell through: mispredict and a BTB write.
    step(1, 1, 1, 16'h1234, 16'h1300, 16'h1235, 0);
    check("tp1_mispredict", 32'(mispredict), 32'd1);
    check("tp1_redirect", 32'(redirect_pc), 32'h1300);
    check("tp1_ctr_taken", 32'(ctr_update_taken), 32'd1);
    check("tp1_wr_valid", 32'(btb_wr_valid), 32'd1);
    check("tp1_wr_index", 32'(btb_wr_index), 32'h34);
    check("tp1_wr_data", 32'(btb_wr_data), 32'h121300);
    idle(1);

    // Correctly predicted not-taken branch: counter update only.
    step(1, 1, 0, 16'h0010, 16'h0777, 16'h0011, 1);
    check("tp2_mispredict", 32'(mispredict), 32'd0);
    check("tp2_ctr_valid", 32'(ctr_update_valid), 32'd1);
    check("tp2_ctr_taken", 32'(ctr_update_taken), 32'd0);
    check("tp2_wr_valid", 32'(btb_wr_valid), 32'd0);

    // Six distinct writes with a stalled port: four queue, two drop.
    for (int i = 0; i < 6; i++)
      step(1, 1, 1, 16'h0100 + 16'(i), 16'h2000 + 16'(i), 16'h0101 + 16'(i), 0);
    check("tp3_drop_count", 32'(drop_count), 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("tp3_head_index", 32'(btb_wr_index), 32'(i));
      check("tp3_head_data", 32'(btb_wr_data), 32'h012000 + 32'(i));
      idle(1);
    end
    check("tp3_drained", 32'(btb_wr_valid), 32'd0);

    // The same branch twice in a row queues once.
    step(1, 1, 1, 16'h0777, 16'h0900, 16'h0900, 0);
    step(1, 1, 1, 16'h0777, 16'h0900, 16'h0900, 0);
    idle(1);
    check("tp4_single_entry", 32'(btb_wr_valid), 32'd0);

    // PC at the top of the address space.
    step(1, 1, 1, 16'hFFFF, 16'h0005, 16'h0000, 1);
    check("tp4_wrap_misp", 32'(mispredict), 32'd1);
    check("tp4_wrap_redirect", 32'(redirect_pc), 32'h0005);
    step(1, 1, 0, 16'hFFFF, 16'h0005, 16'h0000, 1);
    check("tp4_fallthru_misp", 32'(mispredict), 32'd0);
    check("tp4_fallthru_redirect", 32'(redirect_pc), 32'h0000);
    idle(1);
    idle(1);

    // Not-taken branch that fetch followed as taken.
    step(1, 1, 0, 16'h0420, 16'h0500, 16'h0500, 0);
    check("tp5_mispredict", 32'(mispredict), 32'd1);
    check("tp5_redirect", 32'(redirect_pc), 32'h0421);
`ifdef BTB_INVALIDATE_EN
    check("tp5_inval_valid", 32'(btb_wr_valid), 32'd1);
    check("tp5_inval_index", 32'(btb_wr_index), 32'h20);
    check("tp5_inval_data", 32'(btb_wr_data), 32'h04FFFF);
`else
    check("tp5_no_write", 32'(btb_wr_valid), 32'd0);
`endif
    idle(1);

    // Reset while the queue is draining.
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 16'h0A00 + 16'(i), 16'h3000 + 16'(i), 16'h0000, 0);
    idle(1);
    #2;
    apply_reset();
    check("middrain_valid", 32'(btb_wr_valid), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit          v;
      bit          br;
      bit          tk;
      logic [15:0] pc;
      logic [15:0] tgt;
      logic [15:0] pred;
      v  = ($urandom_range(0, 9) != 0);
      br = ($urandom_range(0, 5) != 0);
      tk = $urandom_range(0, 1);
      pc  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pc_pool[$urandom_range(0, 3)];
      tgt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : tgt_pool[$urandom_range(0, 3)];
      case ($urandom_range(0, 2))
        0:       pred = tk ? tgt : pc + 16'd1;
        1:       pred = tgt;
        default: pred = 16'($urandom);
      endcase
      step(v, br, tk, pc, tgt, pred, ($urandom_range(0, 2) == 0));
    end
    for (int n = 0; n < QDEPTH + 1; n++) idle(1);
    check("final_drained", 32'(btb_wr_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
